// File: rtl/datapath_controlpath_if.sv
// ---------------------------------------------------------------------------
// datapath_controlpath_if
// Observation bus of the single-cycle core.
//   opfn : {op, fn} of the instruction currently being executed
//   pc   : current program counter
// master : driven by the core
// slave  : consumers (bench, debug logic)
// ---------------------------------------------------------------------------
interface datapath_controlpath_if #(
  parameter int PC_W = 8
);
  logic [4:0]      opfn;
  logic [PC_W-1:0] pc;

  modport master (output opfn, output pc);
  modport slave  (input  opfn, input  pc);
endinterface

// File: rtl/datapath_controlpath.sv
// ---------------------------------------------------------------------------
// datapath_controlpath
// Single-cycle 16-bit load/store core: PC, instruction ROM, 8x16 register
// file (R0 hard-wired to zero), add/sub ALU, data RAM and the control
// decoder. One instruction completes per rising clk edge.
//
// Ports
//   clk  : system clock, rising edge active
//   rst  : asynchronous active-low reset (clears PC and R1..R7 only)
//   bus  : master side of datapath_controlpath_if (opfn, pc)
//
// Instruction and data memories are plain arrays with combinational reads;
// their contents are loaded from outside and are never touched by reset.
// ---------------------------------------------------------------------------
module datapath_controlpath #(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  datapath_controlpath_if.master bus
);

  localparam int DA_W = $clog2(DMEM_DEPTH);

  // Opcodes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b1010;

  // Next-instruction-address select
  localparam logic [1:0] NIA_SEQ    = 2'b00;
  localparam logic [1:0] NIA_BRANCH = 2'b01;
  localparam logic [1:0] NIA_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Storage
  logic [DATA_W-1:0] imem [0:(2**PC_W)-1];
  logic [DATA_W-1:0] dmem [0:DMEM_DEPTH-1];
  logic [DATA_W-1:0] regs [1:7];

  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   pc_inc;

  // Fetch / fields
  logic [DATA_W-1:0] instr;
  logic [4:0]        opfn;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [DATA_W-1:0] imm_ext;

  // Control
  logic [1:0]        nia;
  logic              reg_dst;
  logic              reg_write;
  logic              alu_src;
  logic              mem_write;
  logic              mem_read;
  logic              mem_to_reg;
  logic [2:0]        alu_fn;

  // Datapath
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              zero;
  logic [DA_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_rdata;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign instr   = imem[pc_reg];
  assign opfn    = instr[15:11];
  assign rd      = instr[8:6];
  assign rs      = instr[5:3];
  assign rt      = instr[2:0];
  assign imm_ext = {{(DATA_W-6){instr[11]}}, instr[11:6]};

  // Control decode. Unknown opcodes fall through as a NOP.
  always_comb begin
    nia        = NIA_SEQ;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    alu_fn     = ALU_ADD;
    case (opfn[4:1])
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_fn    = opfn[0] ? ALU_SUB : ALU_ADD;
      end
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        // Subtract rs - rt; a zero result means equal.
        nia    = NIA_BRANCH;
        alu_fn = ALU_SUB;
      end
      OP_J: begin
        nia = NIA_JUMP;
      end
      default: ;
    endcase
  end

  // Register file read: R0 is a constant zero, not storage.
  assign rs_val = (rs == 3'd0) ? '0 : regs[rs];
  assign rt_val = (rt == 3'd0) ? '0 : regs[rt];

  // ALU
  assign alu_b = alu_src ? imm_ext : rt_val;

  always_comb begin
    case (alu_fn)
      ALU_SUB: alu_res = rs_val - alu_b;
      default: alu_res = rs_val + alu_b;
    endcase
  end

  assign zero = (alu_res == '0);

  // Data memory: address is the low bits of the ALU result.
  assign dmem_addr  = alu_res[DA_W-1:0];
  assign dmem_rdata = mem_read ? dmem[dmem_addr] : '0;

  assign wr_addr = reg_dst ? rd : rt;
  assign wr_data = mem_to_reg ? dmem_rdata : alu_res;

  // Next PC
  assign pc_inc = pc_reg + PC_W'(1);

  always_comb begin
    case (nia)
      NIA_BRANCH: pc_next = zero ? (pc_inc + imm_ext[PC_W-1:0]) : pc_inc;
      NIA_JUMP:   pc_next = instr[PC_W-1:0];
      default:    pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_write && (wr_addr != 3'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Memory keeps its contents through reset; the rst term only blocks
  // stores while reset is held.
  always_ff @(posedge clk) begin
    if (rst && mem_write) begin
      dmem[dmem_addr] <= rt_val;
    end
  end

  assign bus.opfn = opfn;
  assign bus.pc   = pc_reg;

endmodule

// File: tb/tb_datapath_controlpath.sv
// ---------------------------------------------------------------------------
// tb_datapath_controlpath
// Runs two small programs on the core. A behavioural instruction-set model
// predicts each instruction's effect; the expectation is queued when the
// instruction is issued and popped/compared after the clock edge that
// retires it. Directed constant checks cover reset and key program points.
// ---------------------------------------------------------------------------
module tb_datapath_controlpath;

  logic clk;
  logic rst;

  datapath_controlpath_if #(.PC_W(8)) bus ();

  datapath_controlpath #(
    .DATA_W(16),
    .PC_W(8),
    .DMEM_DEPTH(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    int          kind;   // 0 none, 1 register write, 2 memory write
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_imem [0:255];
  logic [15:0] m_dmem [0:255];
  logic [15:0] m_regs [0:7];
  logic [7:0]  m_pc;

  logic [15:0] prog_a [0:9];
  logic [15:0] prog_b [0:15];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'd0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
  endtask

  // Reference instruction-set behaviour for one instruction.
  task automatic model_step();
    logic [15:0] ins;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] sum;
    exp_t e;
    ins = m_imem[m_pc];
    a   = (ins[5:3] == 3'd0) ? 16'h0000 : m_regs[ins[5:3]];
    b   = (ins[2:0] == 3'd0) ? 16'h0000 : m_regs[ins[2:0]];
    imm = {{10{ins[11]}}, ins[11:6]};
    sum = a + imm;
    e.pc = m_pc + 8'd1;
    e.kind = 0;
    e.idx = 0;
    e.val = 16'h0000;
    case (ins[15:12])
      4'h0: begin e.kind = 1; e.idx = int'(ins[8:6]); e.val = ins[11] ? (a - b) : (a + b); end
      4'h2: begin e.kind = 1; e.idx = int'(ins[2:0]); e.val = sum; end
      4'h4: begin e.kind = 1; e.idx = int'(ins[2:0]); e.val = m_dmem[sum[7:0]]; end
      4'h6: begin e.kind = 2; e.idx = int'(sum[7:0]); e.val = b; end
      4'h8: if (a == b) e.pc = m_pc + 8'd1 + imm[7:0];
      4'hA: e.pc = ins[7:0];
      default: ;
    endcase
    if (e.kind == 1 && e.idx != 0) m_regs[e.idx] = e.val;
    if (e.kind == 2) m_dmem[e.idx] = e.val;
    m_pc = e.pc;
    sb.push_back(e);
  endtask

  // Called on a negative edge; returns on a negative edge.
  task automatic run_cycles(input int n);
    exp_t e;
    logic [15:0] ins;
    for (int c = 0; c < n; c++) begin
      ins = m_imem[m_pc];
      $display("pc=%0d instr=%h", m_pc, ins);
      check($sformatf("opfn@pc%0d", m_pc), {11'd0, bus.opfn}, {11'd0, ins[15:11]});
      model_step();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("pc", {8'd0, bus.pc}, {8'd0, e.pc});
      if (e.kind == 1 && e.idx != 0)
        check($sformatf("r%0d", e.idx), dut.regs[e.idx], e.val);
      else if (e.kind == 2)
        check($sformatf("dmem[%0d]", e.idx), dut.dmem[e.idx], e.val);
      @(negedge clk);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pc"}, {8'd0, bus.pc}, 16'h0000);
    for (int i = 1; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), dut.regs[i], 16'h0000);
  endtask

  initial begin
    prog_a = '{16'h2281, 16'h2142, 16'h2143, 16'h011A, 16'h088C,
               16'h6003, 16'h4041, 16'h8002, 16'h2003, 16'hA000};
    prog_b = '{16'h2142, 16'h8002, 16'h21C0, 16'h0142, 16'h2002,
               16'hA007, 16'hA009, 16'h8F82, 16'hF000, 16'h2FC6,
               16'h09F5, 16'h4031, 16'h6037, 16'h4034, 16'hA0FF, 16'hF000};

    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i] = 16'hF000;
      m_imem[i]   = 16'hF000;
      dut.dmem[i] = 16'(i);
      m_dmem[i]   = 16'(i);
    end
    for (int i = 0; i < 10; i++) begin
      dut.imem[i] = prog_a[i];
      m_imem[i]   = prog_a[i];
    end

    #1 rst = 1'b0;
    #10;
    check_cleared("reset");
    check("reset_dmem250", dut.dmem[250], 16'd250);
    check("reset_dmem0", dut.dmem[0], 16'd0);

    @(negedge clk);
    rst = 1'b1;
    model_reset();

    run_cycles(3);
    check("addi_r1", dut.regs[1], 16'd10);
    check("addi_r2", dut.regs[2], 16'd5);
    check("addi_r3", dut.regs[3], 16'd5);

    run_cycles(7);
    check("loop_pc", {8'd0, bus.pc}, 16'd0);
    check("sw_dmem0", dut.dmem[0], 16'd5);
    check("lw_r1", dut.regs[1], 16'd1);
    check("dmem250_kept", dut.dmem[250], 16'd250);

    run_cycles(2);
    check("rerun_r1", dut.regs[1], 16'd10);
    check("rerun_r2", dut.regs[2], 16'd5);
    run_cycles(2);

    // Reset in the middle of the loop: clears at once, memory survives.
    rst = 1'b0;
    #1;
    check_cleared("midreset");
    check("midreset_dmem0", dut.dmem[0], 16'd5);
    @(posedge clk);
    #1;
    check("hold_pc", {8'd0, bus.pc}, 16'h0000);
    check("hold_r3", dut.regs[3], 16'h0000);

    for (int i = 0; i < 16; i++) begin
      dut.imem[i] = prog_b[i];
      m_imem[i]   = prog_b[i];
    end
    dut.imem[255] = 16'hF000;
    m_imem[255]   = 16'hF000;

    @(negedge clk);
    rst = 1'b1;
    model_reset();

    run_cycles(20);
    check("r0_write_ignored_r5", dut.regs[5], 16'd5);
    check("neg_imm_r6", dut.regs[6], 16'hFFFF);
    check("sub_wrap_r7", dut.regs[7], 16'hFFFA);
    check("lw_after_sw_r4", dut.regs[4], 16'hFFFA);
    check("sw_wrap_dmem255", dut.dmem[255], 16'hFFFA);
    check("final_pc", {8'd0, bus.pc}, 16'd5);
    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
